comma_aligner_10b: RTL and testbench

- Word aligner between the deserializer and decoder_8b10b.
- Input is raw 10-bit words at an arbitrary bit offset. The block searches for the K28.x comma (0011111 / 1100000) across word boundaries and locks onto a bit offset.
- It emits boundary-aligned 10-bit code groups with a valid strobe that feeds the decoder's data_in/valid_in.
- It runs in the same clock domain as the encoder/decoder.

---
 rtl/comma_aligner_10b.sv | 176 +++++++++++++++++
 tb/tb_comma_aligner_10b.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comma_aligner_10b.sv
// comma_aligner_10b
//   Word aligner between the deserializer and the 8b/10b decoder. Raw 10-bit
//   words arrive at an arbitrary bit offset. The block hunts for the K28.x
//   comma prefix (0011111 / 1100000) across word boundaries, locks onto a bit
//   offset, and emits boundary-aligned code groups.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   data_in    raw unaligned word, bit 9 = earliest bit in time
//   valid_in   data_in qualifier
//   data_out   aligned code group, bit 9 = first bit ('a')
//   valid_out  data_out qualifier (only while locked)
//   comma_out  data_out carries a comma
//   locked     alignment locked
//   bit_offset current/locked offset, 0..9
//
// States
//   UNLOCKED | no candidate offset, waiting for any comma
//   CHECK    | candidate offset chosen, counting consecutive commas there
//   LOCKED   | alignment declared, counting commas seen at a wrong offset
module comma_aligner_10b #(
  parameter int COMMA_LOCK     = 3,
  parameter int MISALIGN_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] data_in,
  input  logic       valid_in,
  output logic [9:0] data_out,
  output logic       valid_out,
  output logic       comma_out,
  output logic       locked,
  output logic [3:0] bit_offset
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [9:0]  prev_word;
  // The last bit of data_in can never start a candidate or a comma prefix,
  // so the window stops one bit short of the full 20.
  logic [19:1] window;
  logic [9:0]  comma_hit;
  logic        found;
  logic [3:0]  first_k;
  logic        at_offset;
  logic [3:0]  comma_cnt, comma_cnt_nx;
  logic [3:0]  mis_cnt, mis_cnt_nx;
  logic [3:0]  bit_offset_nx;
  logic [3:0]  sel;
  logic [9:0]  cand_sel;
  logic        comma_sel;

  assign window = {prev_word, data_in[9:1]};
  assign locked = (state == LOCKED);

  // Comma detection at every offset; lowest offset wins when several match.
  always_comb begin
    comma_hit = '0;
    first_k   = 4'd0;
    for (int k = 0; k < 10; k++) begin
      comma_hit[k] = (window[19-k -: 7] == 7'b0011111) ||
                     (window[19-k -: 7] == 7'b1100000);
    end
    for (int k = 9; k >= 0; k--) begin
      if (comma_hit[k]) first_k = 4'(k);
    end
    found = |comma_hit;
  end

  always_comb begin
    at_offset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bit_offset == 4'(k)) at_offset = comma_hit[k];
    end
  end

  // Next-state logic. A comma at the current offset always counts as aligned
  // in CHECK/LOCKED even if a lower offset also matches.
  always_comb begin
    state_nx      = state;
    comma_cnt_nx  = comma_cnt;
    mis_cnt_nx    = mis_cnt;
    bit_offset_nx = bit_offset;
    sel           = bit_offset;
    if (valid_in) begin
      case (state)
        UNLOCKED: begin
          if (found) begin
            bit_offset_nx = first_k;
            sel           = first_k;
            comma_cnt_nx  = 4'd1;
            if (COMMA_LOCK <= 1) begin
              state_nx   = LOCKED;
              mis_cnt_nx = 4'd0;
            end else begin
              state_nx = CHECK;
            end
          end
        end
        CHECK: begin
          if (at_offset) begin
            if (comma_cnt != 4'd15) comma_cnt_nx = comma_cnt + 4'd1;
            if (int'(comma_cnt) + 1 >= COMMA_LOCK) begin
              state_nx   = LOCKED;
              mis_cnt_nx = 4'd0;
            end
          end else if (found) begin
            bit_offset_nx = first_k;
            sel           = first_k;
            comma_cnt_nx  = 4'd1;
            if (COMMA_LOCK <= 1) begin
              state_nx   = LOCKED;
              mis_cnt_nx = 4'd0;
            end
          end
        end
        LOCKED: begin
          if (at_offset) begin
            mis_cnt_nx = 4'd0;
          end else if (found) begin
            if (mis_cnt != 4'd15) mis_cnt_nx = mis_cnt + 4'd1;
            if (int'(mis_cnt) + 1 >= MISALIGN_LIMIT) begin
              state_nx     = UNLOCKED;
              comma_cnt_nx = 4'd0;
              mis_cnt_nx   = 4'd0;
            end
          end
        end
        default: state_nx = UNLOCKED;
      endcase
    end
  end

  // Output mux at the selected offset.
  always_comb begin
    cand_sel  = '0;
    comma_sel = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (sel == 4'(k)) begin
        cand_sel  = window[19-k -: 10];
        comma_sel = comma_hit[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= UNLOCKED;
      prev_word  <= '0;
      comma_cnt  <= '0;
      mis_cnt    <= '0;
      bit_offset <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      comma_out  <= 1'b0;
    end else begin
      state      <= state_nx;
      comma_cnt  <= comma_cnt_nx;
      mis_cnt    <= mis_cnt_nx;
      bit_offset <= bit_offset_nx;
      valid_out  <= valid_in && (state_nx == LOCKED);
      if (valid_in) begin
        prev_word <= data_in;
        data_out  <= cand_sel;
        comma_out <= comma_sel;
      end
    end
  end

endmodule

// File: tb/tb_comma_aligner_10b.sv
module tb_comma_aligner_10b;

  localparam int LOCK_N = 3;
  localparam int MIS_N  = 4;

  localparam logic [9:0] K_NEG = 10'b0011111010;
  localparam logic [9:0] K_POS = 10'b1100000101;
  localparam logic [9:0] D215  = 10'b1010101010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic [9:0] data_out;
  logic       valid_out, comma_out, locked;
  logic [3:0] bit_offset;

  int checks = 0;
  int errors = 0;

  comma_aligner_10b #(.COMMA_LOCK(LOCK_N), .MISALIGN_LIMIT(MIS_N)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out), .comma_out(comma_out),
    .locked(locked), .bit_offset(bit_offset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The bit stream is treated as a 20-bit number {previous word, current
  // word}; offsets are extracted with shifts and masks.
  bit         mready = 1'b0;
  logic [9:0] m_prev;
  bit         m_locked, m_hunt;
  int         m_off, m_good, m_bad;
  logic [9:0] m_dout;
  bit         m_vout, m_cout;

  function automatic bit is_comma(input logic [19:0] w, input int k);
    logic [6:0] p;
    p = 7'((w >> (13 - k)) & 20'h7F);
    return (p == 7'b0011111) || (p == 7'b1100000);
  endfunction

  function automatic logic [9:0] group_at(input logic [19:0] w, input int k);
    return 10'((w >> (10 - k)) & 20'h3FF);
  endfunction

  always @(posedge clk) begin
    logic [19:0] w;
    int kmin, sel;
    bit aligned;
    if (rst) begin
      m_prev = '0; m_locked = 0; m_hunt = 0; m_off = 0; m_good = 0; m_bad = 0;
      m_dout = '0; m_vout = 0; m_cout = 0; mready = 1;
    end else if (valid_in) begin
      w = {m_prev, data_in};
      kmin = -1;
      for (int k = 9; k >= 0; k--) if (is_comma(w, k)) kmin = k;
      aligned = is_comma(w, m_off);
      sel = m_off;
      if (m_locked) begin
        if (aligned) m_bad = 0;
        else if (kmin >= 0) begin
          if (m_bad < 15) m_bad++;
          if (m_bad >= MIS_N) begin
            m_locked = 0; m_hunt = 0; m_good = 0; m_bad = 0;
          end
        end
      end else if (m_hunt && aligned) begin
        if (m_good < 15) m_good++;
        if (m_good >= LOCK_N) begin m_locked = 1; m_bad = 0; end
      end else if (kmin >= 0) begin
        m_off = kmin; sel = kmin; m_good = 1; m_hunt = 1;
        if (LOCK_N <= 1) begin m_locked = 1; m_bad = 0; end
      end
      m_dout = group_at(w, sel);
      m_cout = is_comma(w, sel);
      m_vout = m_locked;
      m_prev = data_in;
    end else begin
      m_vout = 0;
    end
  end

  always @(negedge clk) begin
    if (mready) begin
      chk("data_out",   32'(data_out),   32'(m_dout));
      chk("valid_out",  32'(valid_out),  32'(m_vout));
      chk("comma_out",  32'(comma_out),  32'(m_cout));
      chk("locked",     32'(locked),     32'(m_locked));
      chk("bit_offset", 32'(bit_offset), 32'(m_off));
    end
  end

  // ---------------- stimulus ----------------
  bit bq[$];

  task automatic push_group(input logic [9:0] g);
    for (int i = 9; i >= 0; i--) bq.push_back(g[i]);
  endtask

  // Alternating filler bits never form a comma prefix.
  task automatic push_pad(input int n);
    for (int i = 0; i < n; i++) bq.push_back((i % 2) == 0);
  endtask

  task automatic push_pairs(input int n, input bit alt);
    for (int i = 0; i < n; i++) begin
      push_group((alt && (i % 2 == 1)) ? K_POS : K_NEG);
      push_group(D215);
    end
  endtask

  task automatic cyc(input logic [9:0] d, input logic v);
    @(negedge clk);
    rst = 1'b0; data_in = d; valid_in = v;
  endtask

  task automatic send_words(input int n, input int gap);
    for (int j = 0; j < n; j++) begin
      logic [9:0] w;
      for (int i = 9; i >= 0; i--) w[i] = bq.pop_front();
      cyc(w, 1'b1);
      repeat (gap) cyc(10'h155, 1'b0);
    end
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  // Reset is applied with a valid comma word on the bus to show it wins.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; data_in = K_NEG; valid_in = 1'b1;
    settle();
    bq.delete();
  endtask

  initial begin
    do_reset();
    chk("rst_locked",  32'(locked),     0);
    chk("rst_dout",    32'(data_out),   0);

    // Aligned stream at offset 0
    push_pairs(3, 0);
    send_words(5, 0); settle();
    chk("t1_pre_locked", 32'(locked), 0);
    chk("t1_pre_valid",  32'(valid_out), 0);
    send_words(1, 0); settle();
    chk("t1_locked", 32'(locked), 1);
    chk("t1_off",    32'(bit_offset), 0);
    chk("t1_dout",   32'(data_out), 32'(K_NEG));
    chk("t1_comma",  32'(comma_out), 1);
    chk("t1_valid",  32'(valid_out), 1);

    // Stream shifted to offset 3, alternating disparity commas
    do_reset();
    push_pad(3); push_pairs(3, 1);
    send_words(6, 0); settle();
    chk("t2_off",    32'(bit_offset), 3);
    chk("t2_locked", 32'(locked), 1);
    chk("t2_dout",   32'(data_out), 32'(K_NEG));
    chk("t2_comma",  32'(comma_out), 1);
    push_group(D215);
    send_words(1, 0); settle();
    chk("t2_dout_d", 32'(data_out), 32'(D215));
    chk("t2_comma_d", 32'(comma_out), 0);
    chk("t2_valid_d", 32'(valid_out), 1);

    // Four commas at offset 7 while locked at 3 -> loss of lock, then relock
    push_pad(4); push_pairs(4, 1);
    send_words(8, 0); settle();
    chk("t3_unlocked", 32'(locked), 0);
    chk("t3_valid",    32'(valid_out), 0);
    chk("t3_off_hold", 32'(bit_offset), 3);
    push_pairs(3, 1);
    send_words(6, 0); settle();
    chk("t3_relock", 32'(locked), 1);
    chk("t3_off",    32'(bit_offset), 7);
    chk("t3_dout",   32'(data_out), 32'(K_NEG));

    // Locked at 0: 3 misaligned, 1 aligned, 3 misaligned -> stays locked
    do_reset();
    push_pairs(3, 0);
    send_words(6, 0); settle();
    chk("t4_locked0", 32'(locked), 1);
    push_pad(5); push_pairs(3, 0);
    push_pad(5); push_pairs(1, 0);
    push_pad(5); push_pairs(3, 0);
    push_group(D215); push_group(D215);
    send_words(17, 0); settle();
    chk("t4_locked", 32'(locked), 1);
    chk("t4_off",    32'(bit_offset), 0);

    // CHECK at 2 with two commas, then a comma at 5 restarts the count;
    // idle gaps interleaved.
    do_reset();
    push_pad(2); push_pairs(2, 0);
    send_words(4, 0); settle();
    chk("t5_off2",    32'(bit_offset), 2);
    chk("t5_unlock2", 32'(locked), 0);
    push_pad(3); push_pairs(3, 0);
    send_words(1, 2); send_words(1, 0); settle();
    chk("t5_off5",    32'(bit_offset), 5);
    chk("t5_unlock5", 32'(locked), 0);
    send_words(3, 1); send_words(1, 0); settle();
    chk("t5_locked",  32'(locked), 1);
    chk("t5_off",     32'(bit_offset), 5);
    chk("t5_dout",    32'(data_out), 32'(K_NEG));
    chk("t5_valid",   32'(valid_out), 1);
    cyc(10'h155, 1'b0); settle();
    chk("t5_gap_valid",  32'(valid_out), 0);
    chk("t5_gap_locked", 32'(locked), 1);
    chk("t5_gap_dout",   32'(data_out), 32'(K_NEG));

    // Reset while locked
    do_reset();
    chk("t6_locked", 32'(locked), 0);
    chk("t6_valid",  32'(valid_out), 0);
    chk("t6_off",    32'(bit_offset), 0);
    chk("t6_dout",   32'(data_out), 0);
    chk("t6_comma",  32'(comma_out), 0);
    push_pairs(3, 0);
    send_words(5, 0); settle();
    chk("t6_pre_lock", 32'(locked), 0);
    send_words(1, 0); settle();
    chk("t6_relock", 32'(locked), 1);

    cyc(10'h000, 1'b0); cyc(10'h000, 1'b0);
    settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
